// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver: per-channel off/on/blink/PWM with
// run-time period and duty, plus a one-cycle wrap tick per channel.
module led_pattern_ctrl #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 27,
  parameter int unsigned DEFAULT_PERIOD = 50_000_000,
  parameter logic [1:0]  DEFAULT_MODE   = 2'b10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duty,
  output logic [NUM_CH-1:0] LED,
  output logic [NUM_CH-1:0] tick
);

  typedef enum logic [1:0] {
    M_OFF   = 2'b00,
    M_ON    = 2'b01,
    M_BLINK = 2'b10,
    M_PWM   = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_t            mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] count;
    logic             led_q;
    logic             tick_q;
    logic             hit;
    logic             wrap;

    // cfg_ch beyond NUM_CH never matches any channel, so it is ignored
    assign hit  = cfg_we && (cfg_ch == 4'(i));
    assign wrap = (count == period);

    always_ff @(posedge clk) begin
      if (reset) begin
        mode   <= mode_t'(DEFAULT_MODE);
        period <= RST_PERIOD;
        duty   <= '0;
        count  <= '0;
        led_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (hit) begin
        mode   <= mode_t'(cfg_mode);
        period <= cfg_period;
        duty   <= cfg_duty;
        count  <= '0;
        led_q  <= (cfg_mode == M_ON);
        tick_q <= 1'b0;
      end else if (en) begin
        unique case (mode)
          M_OFF: begin
            count  <= '0;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
          end
          M_ON: begin
            count  <= '0;
            led_q  <= 1'b1;
            tick_q <= 1'b0;
          end
          M_BLINK: begin
            count  <= wrap ? '0 : count + 1'b1;
            led_q  <= wrap ? ~led_q : led_q;
            tick_q <= wrap;
          end
          M_PWM: begin
            count  <= wrap ? '0 : count + 1'b1;
            led_q  <= (count < duty);
            tick_q <= wrap;
          end
        endcase
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign LED[i]  = led_q;
    assign tick[i] = tick_q;
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: directed scenarios then random
// traffic, checked against an elapsed-cycle model of each channel.
module tb_led_pattern_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int DEF_P  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_duty;
  logic [NUM_CH-1:0] LED;
  logic [NUM_CH-1:0] tick;

  led_pattern_ctrl #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_PERIOD(DEF_P),
    .DEFAULT_MODE(2'b10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode),
    .cfg_period(cfg_period),
    .cfg_duty(cfg_duty),
    .LED(LED),
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Model: each channel remembers its mode, period, duty and the number
  // of enabled edges since its last reset/write; outputs follow from that.
  int    m_mode [NUM_CH];
  longint m_per [NUM_CH];
  longint m_duty[NUM_CH];
  longint m_n   [NUM_CH];

  logic [2*NUM_CH-1:0] sb_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  done = 0;

  function automatic void model_edge(bit r, bit e, bit we, int ch,
                                     int md, longint p, longint d);
    logic [NUM_CH-1:0] xl, xt;
    xl = '0;
    xt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r) begin
        m_mode[c] = 2; m_per[c] = DEF_P; m_duty[c] = 0; m_n[c] = 0;
      end else if (we && ch == c) begin
        m_mode[c] = md; m_per[c] = p; m_duty[c] = d; m_n[c] = 0;
      end else if (e && m_mode[c] >= 2) begin
        m_n[c]++;
        xt[c] = (m_n[c] % (m_per[c] + 1)) == 0;
      end
      case (m_mode[c])
        0: xl[c] = 1'b0;
        1: xl[c] = 1'b1;
        2: xl[c] = ((m_n[c] / (m_per[c] + 1)) % 2) == 1;
        default:
          xl[c] = (m_n[c] > 0) &&
                  (((m_n[c] - 1) % (m_per[c] + 1)) < m_duty[c]);
      endcase
    end
    sb_q.push_back({xl, xt});
  endfunction

  task automatic cyc(input bit r, input bit e, input bit we,
                     input int ch, input int md, input int p, input int d);
    @(negedge clk);
    reset      = r;
    en         = e;
    cfg_we     = we;
    cfg_ch     = 4'(ch);
    cfg_mode   = 2'(md);
    cfg_period = CNT_W'(p);
    cfg_duty   = CNT_W'(d);
    model_edge(r, e, we, ch, md, p, d);
  endtask

  task automatic idle(input int n, input bit e);
    for (int k = 0; k < n; k++) cyc(0, e, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one DUT output per clock edge, compared with the queue head
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      logic [2*NUM_CH-1:0] exp_v;
      exp_v = sb_q.pop_front();
      vectors++;
      if ({LED, tick} !== exp_v) begin
        miscompares++;
        $display("FAIL vec%0d LED/tick got %b/%b expected %b/%b at %0t",
                 vectors, LED, tick, exp_v[2*NUM_CH-1:NUM_CH],
                 exp_v[NUM_CH-1:0], $time);
      end
    end
  end

  initial begin
    reset = 1; en = 1; cfg_we = 0; cfg_ch = 0; cfg_mode = 0;
    cfg_period = 0; cfg_duty = 0;

    // reset, then free-running default blink; write on a wrap edge
    cyc(1, 1, 1, 0, 1, 0, 0);
    idle(3, 1);
    cyc(0, 1, 1, 0, 2, 3, 0);
    idle(16, 1);

    // PWM duty sweep on ch1
    cyc(0, 1, 1, 1, 3, 9, 3);
    idle(25, 1);
    cyc(0, 1, 1, 1, 3, 9, 0);
    idle(22, 1);
    cyc(0, 1, 1, 1, 3, 9, 12);
    idle(22, 1);

    // static on/off channels
    cyc(0, 1, 1, 2, 1, 5, 0);
    cyc(0, 1, 1, 3, 0, 5, 0);
    idle(10, 1);

    // freeze mid-blink, then resume
    idle(2, 1);
    idle(7, 0);
    idle(10, 1);

    // out-of-range channel, write while disabled
    cyc(0, 1, 1, 5, 1, 0, 0);
    idle(6, 1);
    cyc(0, 0, 1, 3, 2, 1, 0);
    idle(6, 1);

    // reset mid-PWM
    cyc(1, 1, 0, 0, 0, 0, 0);
    idle(12, 1);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      bit r, e, we;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 11) == 0);
      cyc(r, e, we, $urandom_range(0, 7), $urandom_range(0, 3),
          $urandom_range(0, 14), $urandom_range(0, 18));
    end

    @(negedge clk);
    cfg_we = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain queue left %0d required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Multi-channel LED driver generalising the single free-running blinker: NUM_CH independent LED outputs, each with a run-time selectable mode (off, on, blink, PWM), a per-channel period and a PWM duty value. It sits directly between board LED pins and a simple register-write port driven by control logic. After reset, every channel blinks at the legacy rate without any configuration.

## Interface
- NUM_CH, 4: number of LED channels (1..16).
- CNT_W, 27: counter, period and duty width in bits.
- DEFAULT_PERIOD, 50_000_000: reset value of every channel's period (half-period in blink mode).
- DEFAULT_MODE, 2'b10: reset mode of every channel (blink).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  global run enable; low freezes all counters and LEDs.
- cfg_we  in  1  one-cycle config write strobe.
- cfg_ch  in  4  target channel index.
- cfg_mode  in  2  00 off, 01 on, 10 blink, 11 PWM.
- cfg_period  in  CNT_W  new period.
- cfg_duty  in  CNT_W  new duty (PWM only).
- LED  out  NUM_CH  registered LED drive, bit i = channel i.
- tick  out  NUM_CH  one-cycle pulse when channel i's counter wraps.

## Operation
- Per channel: mode, period, duty, count (CNT_W), led bit, tick bit; all registered.
- Reset (reset=1 at an edge): mode=DEFAULT_MODE, period=DEFAULT_PERIOD, duty=0, count=0, LED=0, tick=0. Reset overrides en and cfg_we.
- Config write: on an edge with cfg_we=1 and cfg_ch<NUM_CH, that channel loads mode/period/duty, count<=0, tick<=0, LED bit<=1 if cfg_mode=on, else 0. cfg_ch>=NUM_CH: write ignored, no state change. A write applies even when en=0. Other channels are unaffected.
- en=0 (no write): count, LED and mode hold; tick<=0.
- Off mode: LED=0, count held at 0, tick=0.
- On mode: LED=1, count held at 0, tick=0.
- Blink mode: if count==period then LED toggles, count<=0, tick<=1; else count<=count+1, tick<=0. Half-period = period+1 cycles; period=0 toggles every cycle.
- PWM mode: count runs 0..period then wraps to 0 (tick<=1 on wrap edge). LED<=(count<duty), using pre-increment count; duty=0 is always off, duty>period is always on. PWM frame = period+1 cycles, high time = min(duty, period+1) cycles.
- Comparisons are unsigned, full CNT_W width; count never exceeds period, except that a period lowered by a write is safe because the write clears count.

## Timing
- Write latency: new mode effective at the write edge; in blink mode, first LED toggle occurs period+1 edges after the write edge.
- PWM output lags count by one cycle (registered compare).
- tick is asserted for exactly one cycle per wrap and is never asserted in off/on modes or while en=0.
- Reset mid-blink or mid-PWM: the next edge returns all channels to reset state; blinking restarts from count=0, LED=0.
- Write and wrap on the same edge: the write wins (count=0, tick=0, LED per new mode).

## Test plan
- Reset with NUM_CH=4, DEFAULT_PERIOD=3, en=1: LED=4'b0000 after reset, each bit toggles every 4 cycles, tick pulses every 4 cycles, all channels stay in phase.
- Write ch1 mode=PWM, period=9, duty=3: LED[1] is high 3 of every 10 cycles (lagging by 1), tick[1] fires every 10 cycles. Repeat with duty=0 (always low) and duty=12 (always high).
- Write ch2 mode=on, then ch3 mode=off: LED[2]=1 and LED[3]=0 steadily from the next cycle, tick[2]=tick[3]=0; ch0 and ch1 undisturbed.
- Drop en for 7 cycles mid-blink: LED and count frozen, tick=0; blinking resumes with the remaining count intact.
- Write cfg_ch=5: no channel changes. Write on a wrap edge: count=0 and tick=0 on that edge.
- Assert reset mid-PWM for 1 cycle: all outputs 0, modes revert to blink with period DEFAULT_PERIOD.
